// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply controller: FSM encoding,
// default parameters and a counter-width helper.
package matmul_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_WAIT   = 3'd2,
      ST_ADDR   = 3'd3,
      ST_DRAIN  = 3'd4,
      ST_FINISH = 3'd5
   } state_e;

   localparam int LOG_SIZE_DEFAULT = 2;
   localparam int TIMEOUT_DEFAULT  = 1024;

   // Width of a counter that must hold 0 .. n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/matmul_addr_counter.sv
// Row-major (row, column) scan over an N x N result matrix with
// synchronous clear, step enable, last-element flag and wrap strobe.
module matmul_addr_counter
   import matmul_pkg::*;
#(
   parameter int LOG_SIZE = LOG_SIZE_DEFAULT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic                en,
   output logic [LOG_SIZE-1:0] row,
   output logic [LOG_SIZE-1:0] column,
   output logic                last,
   output logic                wrap
);

   localparam logic [LOG_SIZE-1:0] MAX_IDX = '1;
   localparam logic [LOG_SIZE-1:0] ONE     = LOG_SIZE'(1);

   logic [LOG_SIZE-1:0] row_q, row_d;
   logic [LOG_SIZE-1:0] col_q, col_d;

   assign row    = row_q;
   assign column = col_q;
   assign last   = (row_q == MAX_IDX) && (col_q == MAX_IDX);
   assign wrap   = en && last;

   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      row_d = row_q;
      col_d = col_q;
      if (clr) begin
         row_d = '0;
         col_d = '0;
      end else if (en) begin
         col_d = col_q + ONE;
         if (col_q == MAX_IDX) begin
            row_d = row_q + ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
      if (!rst) begin
         row_q <= '0;
         col_q <= '0;
      end else begin
         row_q <= row_d;
         col_q <= col_d;
      end
   end

endmodule

// File: rtl/matmul_controller.sv
// Sequences one matrix-multiply job: stream N*N operand pairs into the
// multiplier, wait for completion, then drain the result matrix row-major.
module matmul_controller
   import matmul_pkg::*;
#(
   parameter int LOG_SIZE = LOG_SIZE_DEFAULT,
   parameter int TIMEOUT  = TIMEOUT_DEFAULT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [31:0]         in_a,
   input  logic [31:0]         in_b,
   output logic [31:0]         mm_a,
   output logic [31:0]         mm_b,
   output logic                mm_in_stb,
   input  logic                mm_in_ack,
   input  logic                mm_out_stb,
   output logic                mm_out_ack,
   output logic [LOG_SIZE-1:0] mm_row,
   output logic [LOG_SIZE-1:0] mm_column,
   output logic                mm_output_select,
   input  logic [31:0]         mm_out_number,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [31:0]         res_data,
   output logic                res_last,
   output logic                busy,
   output logic                done,
   output logic                error
);

   localparam int LW = 2 * LOG_SIZE;
   localparam int TW = cnt_width(TIMEOUT);

   localparam logic [LW-1:0] LOAD_LAST    = '1;
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

   state_e        state_q, state_d;
   logic [LW-1:0] load_cnt_q, load_cnt_d;
   logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic [31:0]   res_data_q, res_data_d;
   logic          res_last_q, res_last_d;
   logic          res_valid_q, res_valid_d;
   logic          sel_q, sel_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          error_q, error_d;

   logic                in_load;
   logic                in_addr;
   logic                xfer;
   logic                addr_clr;
   logic                addr_en;
   logic                addr_last;
   logic                addr_wrap;
   logic [LOG_SIZE-1:0] addr_row;
   logic [LOG_SIZE-1:0] addr_col;

   matmul_addr_counter #(
      .LOG_SIZE (LOG_SIZE)
   ) u_addr (
      .clk    (clk),
      .rst    (rst),
      .clr    (addr_clr),
      .en     (addr_en),
      .row    (addr_row),
      .column (addr_col),
      .last   (addr_last),
      .wrap   (addr_wrap)
   );

   // The load path is a straight wire to the multiplier, gated by state.
   assign in_load   = (state_q == ST_LOAD);
   assign in_addr   = (state_q == ST_ADDR);
   assign xfer      = in_load && in_valid && mm_in_ack;
   assign in_ready  = in_load && mm_in_ack;
   assign mm_in_stb = in_load && in_valid;
   assign mm_a      = in_load ? in_a : '0;
   assign mm_b      = in_load ? in_b : '0;

   assign addr_clr  = (state_q == ST_IDLE) && start;
   assign addr_en   = (state_q == ST_DRAIN) && res_ready;
   assign mm_row    = in_addr ? addr_row : '0;
   assign mm_column = in_addr ? addr_col : '0;

   assign res_valid        = res_valid_q;
   assign res_data         = res_data_q;
   assign res_last         = res_last_q;
   assign mm_output_select = sel_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign mm_out_ack       = done_q;
   assign error            = error_q;

   always_comb begin
      state_d    = state_q;
      load_cnt_d = load_cnt_q;
      tmo_cnt_d  = tmo_cnt_q;
      error_d    = error_q;
      res_data_d = res_data_q;
      res_last_d = res_last_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d    = ST_LOAD;
               load_cnt_d = '0;
               error_d    = 1'b0;
            end
         end
         ST_LOAD: begin
            if (xfer) begin
               load_cnt_d = load_cnt_q + LW'(1);
               if (load_cnt_q == LOAD_LAST) begin
                  state_d   = ST_WAIT;
                  tmo_cnt_d = '0;
               end
            end
         end
         ST_WAIT: begin
            if (mm_out_stb) begin
               state_d   = ST_ADDR;
               tmo_cnt_d = '0;
            end else if (tmo_cnt_q == TIMEOUT_LAST) begin
               state_d   = ST_FINISH;
               tmo_cnt_d = '0;
               error_d   = 1'b1;
            end else begin
               tmo_cnt_d = tmo_cnt_q + TW'(1);
            end
         end
         ST_ADDR: begin
            // Address was presented for this whole cycle; capture the settled read.
            state_d    = ST_DRAIN;
            res_data_d = mm_out_number;
            res_last_d = addr_last;
         end
         ST_DRAIN: begin
            if (addr_wrap) begin
               state_d = ST_FINISH;
            end else if (res_ready) begin
               state_d = ST_ADDR;
            end
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (state_d != ST_DRAIN) begin
         res_data_d = '0;
         res_last_d = 1'b0;
      end

      // Outputs are decoded from the next state so they are registered with it.
      res_valid_d = (state_d == ST_DRAIN);
      sel_d       = (state_d == ST_ADDR) || (state_d == ST_DRAIN);
      busy_d      = (state_d != ST_IDLE);
      done_d      = (state_d == ST_FINISH);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         load_cnt_q  <= '0;
         tmo_cnt_q   <= '0;
         res_data_q  <= '0;
         res_last_q  <= 1'b0;
         res_valid_q <= 1'b0;
         sel_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         load_cnt_q  <= load_cnt_d;
         tmo_cnt_q   <= tmo_cnt_d;
         res_data_q  <= res_data_d;
         res_last_q  <= res_last_d;
         res_valid_q <= res_valid_d;
         sel_q       <= sel_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
      end
   end

endmodule

// File: doc/matmul_controller.md
MATMUL_CONTROLLER -- requirements
Module: matmul_controller

Interface
REQ-001 Parameter: LOG_SIZE, default 2, log2 of matrix dimension N (N = 2**LOG_SIZE).
REQ-002 Parameter: TIMEOUT, default 1024, maximum WAIT cycles before error.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 start  input  1  one-cycle pulse; begins a job when IDLE, ignored otherwise.
REQ-007 in_valid / in_ready  input / output  1 each  element-pair stream handshake.
REQ-008 in_a, in_b  input  32 each  A and B elements, row-major, N*N pairs per job.
REQ-009 mm_a, mm_b  output  32 each  elements driven to the multiplier.
REQ-010 mm_in_stb  output  1  element valid to the multiplier; mm_in_ack  input  1  multiplier accepts.
REQ-011 mm_out_stb  input  1  multiplier result complete; mm_out_ack  output  1  result consumed.
REQ-012 mm_row, mm_column  output  LOG_SIZE each  result address; mm_output_select  output  1  memory select.
REQ-013 mm_out_number  input  32  addressed result element.
REQ-014 res_valid / res_ready  output / input  1 each  result-stream handshake; res_data  output  32; res_last  output  1.
REQ-015 busy  output  1; done  output  1  (one-cycle pulse); error  output  1  (sticky until next start).

Function
REQ-016 The FSM shall have states IDLE, LOAD, WAIT, ADDR, DRAIN, FINISH.
REQ-017 IDLE->LOAD on start; busy shall be high in every state except IDLE.
REQ-018 In LOAD: in_ready = mm_in_ack; mm_in_stb = in_valid; mm_a/mm_b = in_a/in_b combinationally.
REQ-019 A pair transfers only when in_valid && mm_in_ack; the 2*LOG_SIZE-bit load counter increments per transfer.
REQ-020 LOAD->WAIT on the transfer at which the counter equals N*N-1; the counter then wraps to 0.
REQ-021 In WAIT: the timeout counter increments each cycle; ->ADDR when mm_out_stb is high.
REQ-022 If the timeout counter reaches TIMEOUT-1 without mm_out_stb: set error and go to FINISH.
REQ-023 mm_output_select shall be 1 from ADDR through DRAIN and 0 otherwise.
REQ-024 ADDR drives mm_row/mm_column from the row/column counters for exactly one cycle (read settle), then goes to DRAIN.
REQ-025 DRAIN: res_valid=1 and res_data=registered mm_out_number; hold until res_ready.
REQ-026 DRAIN: res_data/res_last shall stay stable while res_valid && !res_ready.
REQ-027 On each DRAIN handshake: column increments; on column wrap, row increments. Go to ADDR, or to FINISH after (N-1,N-1).
REQ-028 res_last shall be high only with element (N-1,N-1).
REQ-029 FINISH: mm_out_ack and done pulse for one cycle; then ->IDLE.
REQ-030 Result latency: first res_valid 2 cycles after mm_out_stb is sampled high in WAIT.
REQ-031 Sustained throughput: one result per 2 cycles with res_ready tied high.
REQ-032 start during any non-IDLE state shall be ignored; in_ready shall be 0 outside LOAD.
REQ-033 in_valid outside LOAD shall not drive mm_in_stb.

Reset
REQ-034 While rst=0: state=IDLE and all counters=0.
REQ-035 While rst=0: every output 0, including in_ready, mm_in_stb, res_valid, res_last, mm_out_ack, mm_output_select, busy, done and error.
REQ-036 While rst=0: mm_a, mm_b, mm_row, mm_column and res_data shall be 0.
REQ-037 Reset mid-job shall abort immediately with no done pulse; the next start begins a fresh job.

Structure
REQ-038 The FSM state encoding and the TIMEOUT default shall live in shared package matmul_pkg.
REQ-039 The row/column scan shall be one sub-module, matmul_addr_counter (enable, wrap, last flag); everything else is flat.

Verification
REQ-040 Reset, then start; feed 16 pairs (N=4) with mm_in_ack always 1; pulse mm_out_stb -> exactly 16 transfers, then WAIT; 16 results in row-major order; res_last on the 16th; done pulses once.
REQ-041 mm_in_ack toggled 1,0 per cycle during LOAD -> in_ready mirrors it; still exactly 16 pairs accepted; no duplicate or lost element (A=0..15 checked at mm_a).
REQ-042 mm_out_stb never asserted, TIMEOUT=16 -> error=1 16 cycles after WAIT entry; FINISH; done pulse; busy low next cycle.
REQ-043 res_ready held 0 for 5 cycles on element (1,2) -> res_data stable; then the next address is (1,3).
REQ-044 rst asserted on the 3rd DRAIN handshake -> all outputs 0 asynchronously; no done; restart completes a full job correctly.
REQ-045 start pulsed during LOAD and during DRAIN -> no effect on counters or state.
